// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single RAM port, with locked ownership and read-data steering.
// Optional build macro MEM_ARB_RR_EN selects round-robin instead of fixed port-0 priority in IDLE.
module mem_port_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_write,
    output logic          mem_read,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner
);

    // State encoding doubles as the owner output code.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_we;
    logic [AW-1:0]       r_addr;
    logic [DW-1:0]       r_wdata;
    logic [RD_LAT-1:0]   r_pipe_vld;
    logic [RD_LAT-1:0]   r_pipe_id;
    logic [RD_LAT-1:0]   w_vld_in;
    logic [RD_LAT-1:0]   w_id_in;
    logic                w_rv;
    logic [DW-1:0]       r_rdata0;
    logic [DW-1:0]       r_rdata1;
`ifdef MEM_ARB_RR_EN
    logic                r_last;
`endif

    always_comb begin
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        w_state_next = IDLE;
        case (r_state)
            IDLE: begin
                if (m0_req && m1_req) begin
`ifdef MEM_ARB_RR_EN
                    if (r_last) w_gnt0 = 1'b1;
                    else        w_gnt1 = 1'b1;
`else
                    w_gnt0 = 1'b1;
`endif
                end else begin
                    w_gnt0 = m0_req;
                    w_gnt1 = m1_req;
                end
            end
            OWN0:    w_gnt0 = m0_req;
            OWN1:    w_gnt1 = m1_req;
            default: ;
        endcase
        // Grants are combinational, so they must be masked while reset is held.
        if (clr) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
        if (w_gnt0)      w_state_next = m0_lock ? OWN0 : IDLE;
        else if (w_gnt1) w_state_next = m1_lock ? OWN1 : IDLE;
    end

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign w_we      = w_gnt0 ? m0_we : m1_we;
    assign mem_read  = (w_gnt0 | w_gnt1) & ~w_we;
    assign mem_write = (w_gnt0 | w_gnt1) & w_we;
    assign mem_addr  = w_gnt0 ? m0_addr  : (w_gnt1 ? m1_addr  : r_addr);
    assign mem_wdata = w_gnt0 ? m0_wdata : (w_gnt1 ? m1_wdata : r_wdata);
    assign owner     = r_state;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_gnt0 | w_gnt1) begin
                r_addr  <= mem_addr;
                r_wdata <= mem_wdata;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr)         r_last <= 1'b0;
        else if (w_gnt0) r_last <= 1'b0;
        else if (w_gnt1) r_last <= 1'b1;
    end
`endif

    // Return pipeline: stage 0 captures each issued read, last stage lines up with mem_rdata.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign w_vld_in[gi] = mem_read;
                assign w_id_in[gi]  = w_gnt1;
            end else begin : g_body
                assign w_vld_in[gi] = r_pipe_vld[gi-1];
                assign w_id_in[gi]  = r_pipe_id[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_pipe_vld <= '0;
            r_pipe_id  <= '0;
        end else begin
            r_pipe_vld <= w_vld_in;
            r_pipe_id  <= w_id_in;
        end
    end

    assign w_rv      = r_pipe_vld[RD_LAT-1];
    assign m0_rvalid = w_rv & ~r_pipe_id[RD_LAT-1];
    assign m1_rvalid = w_rv &  r_pipe_id[RD_LAT-1];
    assign m0_rdata  = m0_rvalid ? mem_rdata : r_rdata0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : r_rdata1;

    // Held copies keep each port's last returned word stable between its own returns.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (m0_rvalid) r_rdata0 <= mem_rdata;
            if (m1_rvalid) r_rdata1 <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: DUT a uses RD_LAT=1, DUT b uses RD_LAT=3.
// Read expectations go into per-DUT queues at issue time and are matched when rvalid fires.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    // DUT a signals
    logic        a_m0_req, a_m0_we, a_m0_lock, a_m1_req, a_m1_we, a_m1_lock;
    logic [31:0] a_m0_addr, a_m0_wdata, a_m1_addr, a_m1_wdata;
    logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_mem_write, a_mem_read;
    logic [1:0]  a_owner;
    // DUT b signals
    logic        b_m0_req, b_m0_we, b_m0_lock, b_m1_req, b_m1_we, b_m1_lock;
    logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
    logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_mem_write, b_mem_read;
    logic [1:0]  b_owner;

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) dut_a (
        .clk(clk), .clr(clr),
        .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_lock(a_m0_lock), .m0_addr(a_m0_addr),
        .m0_wdata(a_m0_wdata), .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
        .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_lock(a_m1_lock), .m1_addr(a_m1_addr),
        .m1_wdata(a_m1_wdata), .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
        .mem_addr(a_mem_addr), .mem_write(a_mem_write), .mem_read(a_mem_read),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .owner(a_owner)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) dut_b (
        .clk(clk), .clr(clr),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_lock(b_m0_lock), .m0_addr(b_m0_addr),
        .m0_wdata(b_m0_wdata), .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_lock(b_m1_lock), .m1_addr(b_m1_addr),
        .m1_wdata(b_m1_wdata), .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
        .mem_addr(b_mem_addr), .mem_write(b_mem_write), .mem_read(b_mem_read),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .owner(b_owner)
    );

    // RAM models: a returns one cycle after mem_read, b three cycles after.
    logic [31:0] ram_a [0:1023];
    logic [31:0] ram_b [0:1023];
    logic [31:0] b_s0, b_s1, b_s2;
    always @(posedge clk) begin
        if (a_mem_write) ram_a[a_mem_addr[11:2]] <= a_mem_wdata;
        if (a_mem_read)  a_mem_rdata <= ram_a[a_mem_addr[11:2]];
        if (b_mem_write) ram_b[b_mem_addr[11:2]] <= b_mem_wdata;
        b_s0 <= b_mem_read ? ram_b[b_mem_addr[11:2]] : 32'h0;
        b_s1 <= b_s0;
        b_s2 <= b_s1;
    end
    assign b_mem_rdata = b_s2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic p, input logic [31:0] d);
        exp_t e;
        e.port = p; e.data = d; e.due = cyc + 1;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic p, input logic [31:0] d);
        exp_t e;
        e.port = p; e.data = d; e.due = cyc + 3;
        qb.push_back(e);
    endtask

    task automatic idle_all();
        a_m0_req = 0; a_m0_we = 0; a_m0_lock = 0; a_m0_addr = 0; a_m0_wdata = 0;
        a_m1_req = 0; a_m1_we = 0; a_m1_lock = 0; a_m1_addr = 0; a_m1_wdata = 0;
        b_m0_req = 0; b_m0_we = 0; b_m0_lock = 0; b_m0_addr = 0; b_m0_wdata = 0;
        b_m1_req = 0; b_m1_we = 0; b_m1_lock = 0; b_m1_addr = 0; b_m1_wdata = 0;
    endtask

    // Return monitors: every cycle the rvalid pair must match the scoreboard head.
    always @(negedge clk) begin : mon_a
        logic [1:0]  ev;
        logic [31:0] ed;
        if (!clr) begin
            ev = 2'b00; ed = 32'h0;
            if (qa.size() > 0 && qa[0].due <= cyc) begin
                ev = qa[0].port ? 2'b10 : 2'b01;
                ed = qa[0].data;
                qa.delete(0);
            end
            chk("a_rvalid", 64'({a_m1_rvalid, a_m0_rvalid}), 64'(ev));
            if (ev != 2'b00) chk("a_rdata", 64'(ev[0] ? a_m0_rdata : a_m1_rdata), 64'(ed));
        end
    end

    always @(negedge clk) begin : mon_b
        logic [1:0]  ev;
        logic [31:0] ed;
        if (!clr) begin
            ev = 2'b00; ed = 32'h0;
            if (qb.size() > 0 && qb[0].due <= cyc) begin
                ev = qb[0].port ? 2'b10 : 2'b01;
                ed = qb[0].data;
                qb.delete(0);
            end
            chk("b_rvalid", 64'({b_m1_rvalid, b_m0_rvalid}), 64'(ev));
            if (ev != 2'b00) chk("b_rdata", 64'(ev[0] ? b_m0_rdata : b_m1_rdata), 64'(ed));
        end
    end

    initial begin
        logic [1:0] exp_g;
        for (int i = 0; i < 1024; i++) begin
            ram_a[i] = 32'hA000_0000 | 32'(i << 2);
            ram_b[i] = 32'hB000_0000 | 32'(i << 2);
        end
        ram_a[4] = 32'hDEAD_BEEF;
        idle_all();
        clr = 1'b1;
        step(); step();
        #3;
        chk("rst_owner", 64'(a_owner), 64'(2'b00));
        chk("rst_gnt", 64'({a_m1_gnt, a_m0_gnt}), 64'(2'b00));
        chk("rst_rvalid", 64'({a_m1_rvalid, a_m0_rvalid, b_m1_rvalid, b_m0_rvalid}), 64'(4'h0));
        chk("rst_strobes", 64'({a_mem_write, a_mem_read}), 64'(2'b00));
        chk("rst_rdata", 64'({a_m1_rdata, a_m0_rdata}), 64'h0);
        step();
        clr = 1'b0;

        // Reset with reads in flight
        step();
        a_m0_req = 1; a_m0_lock = 1; a_m0_addr = 32'h20; push_a(0, 32'hA000_0020);
        b_m0_req = 1; b_m0_addr = 32'h0; push_b(0, 32'hB000_0000);
        #3 chk("t1_a_gnt0", 64'(a_m0_gnt), 64'(1'b1));
        step();
        a_m0_addr = 32'h24; push_a(0, 32'hA000_0024);
        b_m0_req = 0; b_m1_req = 1; b_m1_addr = 32'h4; push_b(1, 32'hB000_0004);
        #3 chk("t1_owner_locked", 64'(a_owner), 64'(2'b01));
        step();
        clr = 1'b1;
        qa.delete(); qb.delete();
        idle_all();
        #3;
        chk("t1_clr_owner", 64'(a_owner), 64'(2'b00));
        chk("t1_clr_rvalid", 64'({a_m1_rvalid, a_m0_rvalid, b_m1_rvalid, b_m0_rvalid}), 64'(4'h0));
        step();
        clr = 1'b0;
        repeat (5) step();

        // Single read, latency 1
        a_m0_req = 1; a_m0_addr = 32'h10; push_a(0, 32'hDEAD_BEEF);
        #3;
        chk("t2_gnt", 64'({a_m1_gnt, a_m0_gnt}), 64'(2'b01));
        chk("t2_mem_read", 64'({a_mem_write, a_mem_read}), 64'(2'b01));
        chk("t2_mem_addr", 64'(a_mem_addr), 64'(32'h10));
        step();
        idle_all();
        #3;
        chk("t2_strobe_off", 64'(a_mem_read), 64'(1'b0));
        chk("t2_addr_hold", 64'(a_mem_addr), 64'(32'h10));
        chk("t2_m1_rdata_hold", 64'(a_m1_rdata), 64'h0);
        step();

        // Contention from reset
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            a_m0_req = 1; a_m0_addr = 32'h40 + 32'(4 * i);
            a_m1_req = 1; a_m1_addr = 32'h80 + 32'(4 * i);
`ifdef MEM_ARB_RR_EN
            exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b01;
`endif
            if (exp_g[0]) push_a(0, 32'hA000_0040 + 32'(4 * i));
            else          push_a(1, 32'hA000_0080 + 32'(4 * i));
            #3 chk("t3_gnt", 64'({a_m1_gnt, a_m0_gnt}), 64'(exp_g));
        end
        step();
        idle_all();
        step();

        // Locked burst write by m1 with m0 waiting
        for (int i = 0; i < 4; i++) begin
            a_m1_req = 1; a_m1_we = 1; a_m1_lock = (i < 3);
            a_m1_addr = 32'h100 + 32'(4 * i); a_m1_wdata = 32'h5500_0000 + 32'(i);
            if (i > 0) begin a_m0_req = 1; a_m0_addr = 32'h30; end
            #3;
            chk("t4_gnt", 64'({a_m1_gnt, a_m0_gnt}), 64'(2'b10));
            chk("t4_write", 64'({a_mem_write, a_mem_read}), 64'(2'b10));
            chk("t4_addr", 64'(a_mem_addr), 64'(32'h100 + 32'(4 * i)));
            chk("t4_wdata", 64'(a_mem_wdata), 64'(32'h5500_0000 + 32'(i)));
            if (i > 0) chk("t4_owner", 64'(a_owner), 64'(2'b10));
            step();
        end
        a_m1_req = 0; a_m1_we = 0; a_m1_lock = 0;
        push_a(0, 32'hA000_0030);
        #3;
        chk("t4_m0_after", 64'({a_m1_gnt, a_m0_gnt}), 64'(2'b01));
        chk("t4_owner_free", 64'(a_owner), 64'(2'b00));
        step();
        idle_all();
        step();

        // Release of locked ownership
        a_m0_req = 1; a_m0_lock = 1; a_m0_addr = 32'h14; push_a(0, 32'hA000_0014);
        #3 chk("t5_lock_gnt", 64'(a_m0_gnt), 64'(1'b1));
        step();
        a_m0_req = 0; a_m0_lock = 0;
        a_m1_req = 1; a_m1_addr = 32'h104;
        #3;
        chk("t5_no_gnt", 64'({a_m1_gnt, a_m0_gnt}), 64'(2'b00));
        chk("t5_owner", 64'(a_owner), 64'(2'b01));
        chk("t5_no_read", 64'(a_mem_read), 64'(1'b0));
        step();
        push_a(1, 32'h5500_0001);
        #3;
        chk("t5_m1_gnt", 64'({a_m1_gnt, a_m0_gnt}), 64'(2'b10));
        chk("t5_idle", 64'(a_owner), 64'(2'b00));
        step();
        idle_all();
        step();

        // RD_LAT=3 interleaved returns
        b_m0_req = 1; b_m0_addr = 32'h0; push_b(0, 32'hB000_0000);
        #3 chk("t6_g0", 64'({b_m1_gnt, b_m0_gnt}), 64'(2'b01));
        step();
        b_m0_req = 0; b_m1_req = 1; b_m1_addr = 32'h4; push_b(1, 32'hB000_0004);
        #3 chk("t6_g1", 64'({b_m1_gnt, b_m0_gnt}), 64'(2'b10));
        step();
        b_m1_req = 0; b_m0_req = 1; b_m0_addr = 32'h8; push_b(0, 32'hB000_0008);
        #3 chk("t6_g2", 64'({b_m1_gnt, b_m0_gnt}), 64'(2'b01));
        step();
        idle_all();
        repeat (6) step();

        chk("qa_drained", 64'(qa.size()), 64'h0);
        chk("qb_drained", 64'(qb.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
